rng_share_ctrl: RTL and testbench
=================================

# rng_share_ctrl

Sequencer and round-robin arbiter for the masking randomness source. It drives the reset, load and enable controls and the 96-bit seed of the three 32-bit PRNG instances, and runs them through a deterministic init/warm-up sequence. It then hands each fresh PRNG output word to exactly one of N_REQ masked-gadget requesters, so no random word is ever reused across shares.

## Interface
- COEFF_SZ, 16, width of one random coefficient; a word is 6*COEFF_SZ bits (r1..r6 packed, r1 in MSBs).
- N_REQ, 4, number of requesters (2..8).
- WARMUP, 4, PRNG cycles discarded after load before first grant (1..15).
- RESEED_PERIOD, 1024, grants between automatic reseeds (power of two, ≥16; used only with RNG_RESEED_EN).
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- seed_in  in  6*COEFF_SZ  initial seed; bits [6C-1:4C] go to PRNG_0, [4C-1:2C] to PRNG_1, [2C-1:0] to PRNG_2.
- seed_valid  in  1  seed_in valid; sampled in IDLE (and in RUN with RNG_RESEED_EN).
- prng_out  in  6*COEFF_SZ  concatenated PRNG outputs {r1..r6}.
- prng_rstn  out  1  PRNG reset, active-low.
- prng_load  out  1  PRNG seed load strobe.
- prng_enable  out  1  PRNG advance enable.
- prng_seed  out  6*COEFF_SZ  seed presented to the PRNGs.
- req  in  N_REQ  per-requester request, level.
- gnt  out  N_REQ  one-hot grant pulse, one cycle.
- rnd_data  out  6*COEFF_SZ  random word, valid with gnt.
- rnd_valid  out  1  OR of gnt.
- ready  out  1  high only in RUN.

## Operation
- FSM states: IDLE, RST, LOAD, WARM, RUN. All outputs registered and decoded from the next state, so each output reflects the state in the same cycle the FSM occupies it.
- IDLE: prng_rstn=0, prng_enable=0. seed_valid=1 at an edge captures seed_in into prng_seed and moves to RST.
- RST, 1 cycle: prng_rstn=0, then LOAD.
- LOAD, 1 cycle: prng_rstn=1, prng_load=1, then WARM.
- WARM, WARMUP cycles: prng_enable=1, warm counter counts down, no grants, then RUN.
- RUN: prng_enable=1 continuously, so the PRNG yields a new word every cycle. At most one grant per cycle.
- Arbitration: round-robin. Search starts at index ptr, where ptr is the index after the last granted requester (reset 0). On a grant, gnt[i]=1 for one cycle, rnd_data=prng_out sampled at that edge, and ptr=(i+1) mod N_REQ.
- Requesters drop req the cycle after gnt. A held req is granted again, with a new word, once round-robin order permits.
- rnd_data holds its last value when rnd_valid=0.

## Timing
- Reset values: prng_rstn=0, prng_load=0, prng_enable=0, prng_seed=0, gnt=0, rnd_valid=0, rnd_data=0, ready=0, ptr=0, state IDLE.
- seed_valid seen at edge E0: RST during E0..E1, LOAD E1..E2, WARM E2..E2+WARMUP, ready=1 from edge E2+WARMUP.
- Grant latency is 1 cycle: req sampled at edge E gives gnt/rnd_data in cycle E..E+1. Sustained requests get one grant every cycle.
- Consecutive grants always carry different prng_out samples. A word is never granted twice.
- Requests outside RUN are ignored, not queued.
- rst_n low at any time forces the reset values immediately, including mid-grant. After release the block restarts in IDLE and waits for seed_valid.

## Configuration
- RNG_RESEED_EN defined: a grant counter counts grants in RUN.
  - On reaching RESEED_PERIOD, or on seed_valid=1 in RUN, the FSM goes RUN→RST→LOAD→WARM→RUN and the counter clears.
  - Counter reseed: prng_seed ← prng_seed XOR the prng_out sampled at the transition edge.
  - External reseed: prng_seed ← seed_in. External wins if both occur together.
  - A grant coinciding with the transition edge is still issued. ready=0 and there are no grants during reseed.
- RNG_RESEED_EN undefined: no counter. seed_valid is ignored outside IDLE and RUN is permanent until reset.

## Test plan
- Init: rst_n release, seed_in=96'h70c21021_81e06c70_50b210bd, seed_valid pulse at edge 0 -> prng_rstn low 1 cycle from edge 0, prng_load high cycle 1, ready at edge 6 (WARMUP=4), prng_seed equals seed_in.
- Round-robin: req=4'b1111 held 8 cycles in RUN -> gnt sequence 0001,0010,0100,1000 repeated twice; all 8 rnd_data values match the PRNG model and are pairwise distinct.
- Single requester: req=4'b0100 held -> gnt=0100 every cycle; the word at cycle k equals the model output k.
- Pre-ready requests: req=4'b0001 during WARM -> no gnt until first RUN edge, then gnt=0001 one cycle later.
- Async reset mid-grant: rst_n low during a gnt cycle -> gnt, rnd_valid, ready and prng_enable drop immediately; after release no grants until a new seed_valid.
- RNG_RESEED_EN with RESEED_PERIOD=16: 16 grants -> ready falls, RST/LOAD/WARM sequence runs, new prng_seed equals old XOR sampled prng_out, grants resume after WARMUP.

Source files
------------

// File: rtl/rng_share_ctrl.sv
// rng_share_ctrl: sequencer and round-robin arbiter for the masking randomness source.
//
// Brings three 32-bit PRNG instances through reset, seed load and warm-up, then hands each
// fresh PRNG word to exactly one requester per cycle, so no word is ever shared.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   seed_in      seed word; seed_valid strobes it in (IDLE, and RUN when reseeding is built in)
//   prng_out     concatenated PRNG outputs {r1..r6}
//   prng_rstn    PRNG reset (active-low); prng_load seed load strobe; prng_enable advance
//   prng_seed    seed presented to the PRNGs
//   req          per-requester level request
//   gnt          one-hot grant pulse; rnd_data is valid with it; rnd_valid = |gnt
//   ready        high only while in RUN
//
// Optional feature: define RNG_RESEED_EN to add the grant counter and in-service reseeding
// (automatic every RESEED_PERIOD grants, or on seed_valid while in RUN).

module rng_share_ctrl #(
   parameter int unsigned COEFF_SZ      = 16,
   parameter int unsigned N_REQ         = 4,
   parameter int unsigned WARMUP        = 4,
   parameter int unsigned RESEED_PERIOD = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6*COEFF_SZ-1:0] seed_in,
   input  logic                  seed_valid,
   input  logic [6*COEFF_SZ-1:0] prng_out,
   output logic                  prng_rstn,
   output logic                  prng_load,
   output logic                  prng_enable,
   output logic [6*COEFF_SZ-1:0] prng_seed,
   input  logic [N_REQ-1:0]      req,
   output logic [N_REQ-1:0]      gnt,
   output logic [6*COEFF_SZ-1:0] rnd_data,
   output logic                  rnd_valid,
   output logic                  ready
);

   localparam int unsigned WordW = 6 * COEFF_SZ;
   localparam int unsigned PtrW  = $clog2(N_REQ);
   localparam int unsigned WarmW = 4;

   if (N_REQ < 2 || N_REQ > 8 || WARMUP < 1 || WARMUP > 15 || RESEED_PERIOD < 16 ||
       (RESEED_PERIOD & (RESEED_PERIOD - 1)) != 0) begin : g_bad_params
      $error("rng_share_ctrl: unsupported parameter combination");
   end

   typedef enum logic [2:0] {StIdle, StRst, StLoad, StWarm, StRun} state_e;

   state_e             state_q, state_d;
   logic [WarmW-1:0]   warm_q, warm_d;
   logic [PtrW-1:0]    ptr_q, ptr_d;
   logic [PtrW-1:0]    idx;
   logic               found;
   logic [N_REQ-1:0]   gnt_d;
   logic [WordW-1:0]   seed_d;

   // Round-robin search starting at ptr_q; grants only while the FSM already sits in RUN.
   always_comb begin
      gnt_d = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = '0;
      if (state_q == StRun) begin
         for (int unsigned j = 0; j < N_REQ; j++) begin
            idx = PtrW'((32'(ptr_q) + j) % N_REQ);
            if (!found && req[idx]) begin
               found      = 1'b1;
               gnt_d[idx] = 1'b1;
               ptr_d      = (32'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
            end
         end
      end
   end

`ifdef RNG_RESEED_EN
   localparam int unsigned CntW = $clog2(RESEED_PERIOD);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            reseed_due;

   // The grant that completes the period is issued on the same edge that leaves RUN.
   assign reseed_due = (|gnt_d) && (cnt_q == CntW'(RESEED_PERIOD - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_d == StRst) begin
         cnt_d = '0;
      end else if (|gnt_d) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      seed_d  = prng_seed;
      unique case (state_q)
         StIdle: begin
            if (seed_valid) begin
               state_d = StRst;
               seed_d  = seed_in;
            end
         end
         StRst:  state_d = StLoad;
         StLoad: begin
            state_d = StWarm;
            warm_d  = WarmW'(WARMUP - 1);
         end
         StWarm: begin
            if (warm_q == '0) begin
               state_d = StRun;
            end else begin
               warm_d = warm_q - 1'b1;
            end
         end
         StRun: begin
`ifdef RNG_RESEED_EN
            // External seed takes priority over the periodic self-reseed.
            if (seed_valid) begin
               state_d = StRst;
               seed_d  = seed_in;
            end else if (reseed_due) begin
               state_d = StRst;
               seed_d  = prng_seed ^ prng_out;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from state_d so they line up with the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         warm_q      <= '0;
         ptr_q       <= '0;
         prng_seed   <= '0;
         prng_rstn   <= 1'b0;
         prng_load   <= 1'b0;
         prng_enable <= 1'b0;
         ready       <= 1'b0;
         gnt         <= '0;
         rnd_valid   <= 1'b0;
         rnd_data    <= '0;
      end else begin
         state_q     <= state_d;
         warm_q      <= warm_d;
         ptr_q       <= ptr_d;
         prng_seed   <= seed_d;
         prng_rstn   <= (state_d != StIdle) && (state_d != StRst);
         prng_load   <= (state_d == StLoad);
         prng_enable <= (state_d == StWarm) || (state_d == StRun);
         ready       <= (state_d == StRun);
         gnt         <= gnt_d;
         rnd_valid   <= |gnt_d;
         if (|gnt_d) begin
            rnd_data <= prng_out;
         end
      end
   end

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Self-checking bench for rng_share_ctrl: a xorshift PRNG environment model feeds prng_out,
// and expectations come from a word-index model (k-th word = seed advanced k times) plus a
// round-robin arbiter model. Build with RNG_RESEED_EN defined to also exercise reseeding.

module tb_rng_share_ctrl;

   localparam int unsigned COEFF_SZ      = 16;
   localparam int unsigned N_REQ         = 4;
   localparam int unsigned WARMUP        = 4;
   localparam int unsigned RESEED_PERIOD = 16;
   localparam int unsigned W             = 6 * COEFF_SZ;
   localparam logic [95:0] SEED0         = 96'h70c21021_81e06c70_50b210bd;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [W-1:0]     seed_in;
   logic             seed_valid;
   logic [W-1:0]     prng_out;
   logic             prng_rstn;
   logic             prng_load;
   logic             prng_enable;
   logic [W-1:0]     prng_seed;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [W-1:0]     rnd_data;
   logic             rnd_valid;
   logic             ready;

   int n_assert = 0;
   int n_fail   = 0;
   int edge_no  = 0;
   int run_edge = 0;
   int mptr     = 0;
   logic [W-1:0] cur_seed;
   logic [W-1:0] exp_data;
   logic [W-1:0] prng_st;

   always #5 clk = ~clk;

   rng_share_ctrl #(
      .COEFF_SZ      (COEFF_SZ),
      .N_REQ         (N_REQ),
      .WARMUP        (WARMUP),
      .RESEED_PERIOD (RESEED_PERIOD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seed_in     (seed_in),
      .seed_valid  (seed_valid),
      .prng_out    (prng_out),
      .prng_rstn   (prng_rstn),
      .prng_load   (prng_load),
      .prng_enable (prng_enable),
      .prng_seed   (prng_seed),
      .req         (req),
      .gnt         (gnt),
      .rnd_data    (rnd_data),
      .rnd_valid   (rnd_valid),
      .ready       (ready)
   );

   function automatic logic [31:0] xs32(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   function automatic logic [95:0] step(input logic [95:0] w);
      return {xs32(w[95:64]), xs32(w[63:32]), xs32(w[31:0])};
   endfunction

   function automatic logic [95:0] word_at(input logic [95:0] s, input int n);
      logic [95:0] w;
      w = s;
      for (int i = 0; i < n; i++) w = step(w);
      return w;
   endfunction

   // PRNG environment: three xorshift32 lanes driven by the DUT's control outputs.
   always @(posedge clk) begin
      if (!prng_rstn)       prng_st <= '0;
      else if (prng_load)   prng_st <= prng_seed;
      else if (prng_enable) prng_st <= step(prng_st);
   end
   assign prng_out = prng_st;

   function automatic logic [N_REQ-1:0] arb_pick(input logic [N_REQ-1:0] r);
      for (int j = 0; j < N_REQ; j++) begin
         int k = (mptr + j) % N_REQ;
         if (r[k]) begin
            mptr = (k + 1) % N_REQ;
            return N_REQ'(1) << k;
         end
      end
      return '0;
   endfunction

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_no++;
   endtask

   task automatic run_cycle(input logic [N_REQ-1:0] r, input string tag, input bit exp_rdy);
      logic [N_REQ-1:0] eg;
      req = r;
      tick();
      eg = arb_pick(r);
      if (eg != '0) exp_data = word_at(cur_seed, WARMUP + edge_no - run_edge - 1);
      chk({tag, "_gnt"}, 96'(gnt), 96'(eg));
      chk({tag, "_valid"}, 96'(rnd_valid), 96'(|eg));
      chk({tag, "_data"}, rnd_data, exp_data);
      chk({tag, "_ready"}, 96'(ready), 96'(exp_rdy));
   endtask

   task automatic seed_and_wait(input logic [W-1:0] s);
      int e0;
      bit seen;
      seed_in    = s;
      seed_valid = 1'b1;
      tick();
      seed_valid = 1'b0;
      e0   = edge_no;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (ready) seen = 1'b1;
      end
      chk("ready_seen", 96'(ready), 96'(1));
      chk("ready_latency", 96'(edge_no - e0), 96'(2 + WARMUP));
      run_edge = edge_no;
      cur_seed = s;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] words [8];
      logic [W-1:0] s2;
      logic [W-1:0] nseed;
      bit           distinct;

      rst_n = 1'b0; seed_in = '0; seed_valid = 1'b0; req = '0; exp_data = '0;
      tick(); tick();
      chk("rst_prng_rstn", 96'(prng_rstn), 96'(0));
      chk("rst_prng_load", 96'(prng_load), 96'(0));
      chk("rst_prng_en", 96'(prng_enable), 96'(0));
      chk("rst_seed", prng_seed, 96'(0));
      chk("rst_gnt", 96'(gnt), 96'(0));
      chk("rst_valid", 96'(rnd_valid), 96'(0));
      chk("rst_data", rnd_data, 96'(0));
      chk("rst_ready", 96'(ready), 96'(0));

      rst_n = 1'b1;
      tick(); tick();
      chk("idle_ready", 96'(ready), 96'(0));
      chk("idle_rstn", 96'(prng_rstn), 96'(0));

      // Init sequence, edge by edge.
      seed_in = SEED0; seed_valid = 1'b1;
      tick();
      seed_valid = 1'b0;
      chk("e0_rstn", 96'(prng_rstn), 96'(0));
      chk("e0_load", 96'(prng_load), 96'(0));
      chk("e0_seed", prng_seed, SEED0);
      tick();
      chk("e1_rstn", 96'(prng_rstn), 96'(1));
      chk("e1_load", 96'(prng_load), 96'(1));
      chk("e1_en", 96'(prng_enable), 96'(0));
      tick();
      chk("e2_load", 96'(prng_load), 96'(0));
      chk("e2_en", 96'(prng_enable), 96'(1));
      req = 4'b0001;  // requested during WARM: must not be served early
      for (int k = 3; k <= 5; k++) begin
         tick();
         chk("warm_ready", 96'(ready), 96'(0));
         chk("warm_gnt", 96'(gnt), 96'(0));
      end
      tick();
      chk("e6_ready", 96'(ready), 96'(1));
      chk("e6_gnt", 96'(gnt), 96'(0));
      run_edge = edge_no; cur_seed = SEED0; mptr = 0;
      run_cycle(4'b0001, "preready", 1'b1);

      // Round-robin with all requesters active.
      for (int i = 0; i < 8; i++) begin
         run_cycle(4'b1111, "rr", 1'b1);
         words[i] = rnd_data;
      end
      distinct = 1'b1;
      for (int i = 0; i < 8; i++)
         for (int j = i + 1; j < 8; j++)
            if (words[i] == words[j]) distinct = 1'b0;
      chk("rr_distinct", 96'(distinct), 96'(1));

      for (int i = 0; i < 5; i++) run_cycle(4'b0100, "single", 1'b1);

      // Asynchronous reset in the middle of a grant cycle.
      run_cycle(4'b1111, "mid", 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_gnt", 96'(gnt), 96'(0));
      chk("arst_valid", 96'(rnd_valid), 96'(0));
      chk("arst_ready", 96'(ready), 96'(0));
      chk("arst_en", 96'(prng_enable), 96'(0));
      chk("arst_data", rnd_data, 96'(0));
      tick();
      rst_n = 1'b1; mptr = 0; exp_data = '0;
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_gnt", 96'(gnt), 96'(0));
         chk("post_rst_ready", 96'(ready), 96'(0));
      end
      req = '0;

`ifndef RNG_RESEED_EN
      s2 = {$urandom() | 32'h1, $urandom() | 32'h1, $urandom() | 32'h1};
      seed_and_wait(s2);
      for (int i = 0; i < 40; i++) begin
         if (i == 20) begin
            seed_in = ~cur_seed; seed_valid = 1'b1;
         end
         run_cycle(4'($urandom_range(0, 15)), "rand", 1'b1);
         seed_valid = 1'b0;
         if (i == 20) chk("ext_seed_ignored", prng_seed, cur_seed);
      end
`else
      s2 = {$urandom() | 32'h1, $urandom() | 32'h1, $urandom() | 32'h1};
      seed_and_wait(s2);
      for (int i = 0; i < 16; i++) run_cycle(4'b1111, "rs_grant", i < 15);
      nseed = s2 ^ exp_data;
      chk("rs_seed", prng_seed, nseed);
      chk("rs_rstn", 96'(prng_rstn), 96'(0));
      tick();
      chk("rs_load", 96'(prng_load), 96'(1));
      chk("rs_load_gnt", 96'(gnt), 96'(0));
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rs_warm_ready", 96'(ready), 96'(0));
         chk("rs_warm_gnt", 96'(gnt), 96'(0));
         chk("rs_hold_data", rnd_data, exp_data);
      end
      tick();
      chk("rs_ready", 96'(ready), 96'(1));
      chk("rs_ready_gnt", 96'(gnt), 96'(0));
      run_edge = edge_no; cur_seed = nseed;
      for (int i = 0; i < 4; i++) run_cycle(4'b1111, "rs_resume", 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
